// File: rtl/elevator_pkg.sv
// Shared elevator definitions used by the SOS alarm controller.
//   sos_state_t : emergency FSM states
//   sos_cause_t : reason code reported on sos_cause
//   CLK_HZ      : system clock frequency
//   ctr_w()     : counter width for a terminal count, never narrower than 1 bit
package elevator_pkg;

    localparam int CLK_HZ = 100_000_000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMING   = 2'd1,
        ALARM    = 2'd2,
        CLEARING = 2'd3
    } sos_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'b00,
        CAUSE_BTN   = 2'b01,
        CAUSE_STALL = 2'b10
    } sos_cause_t;

    function automatic int ctr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sos_alarm_ctrl_if.sv
// Signal bundle between the cab/elevator side and the SOS alarm controller.
//   alarm_btn, clear_btn, motor_busy : into the controller
//   sos_en, motion_inhibit, sos_cause, alarm_pulse : out of the controller
//   dbg_state : current FSM state, observation only
// All signals are plain levels (alarm_pulse is a one-cycle strobe); there is
// no valid/ready handshake on this bundle.
// Modports: master = cab/elevator side (drives inputs), slave = controller.
interface sos_alarm_ctrl_if;
    import elevator_pkg::*;

    logic       alarm_btn;
    logic       clear_btn;
    logic       motor_busy;
    logic       sos_en;
    logic       motion_inhibit;
    logic [1:0] sos_cause;
    logic       alarm_pulse;
    sos_state_t dbg_state;

    modport master (
        output alarm_btn, clear_btn, motor_busy,
        input  sos_en, motion_inhibit, sos_cause, alarm_pulse, dbg_state
    );

    modport slave (
        input  alarm_btn, clear_btn, motor_busy,
        output sos_en, motion_inhibit, sos_cause, alarm_pulse, dbg_state
    );
endinterface

// File: rtl/sos_debounce.sv
// Two-flop synchroniser followed by a stable-level debouncer.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   din   : raw asynchronous button level
//   dout  : debounced level; follows din after 2 + DEBOUNCE_CYCLES cycles
// The output only changes once the synchronised input has disagreed with it
// for DEBOUNCE_CYCLES consecutive samples; any agreeing sample restarts the count.
module sos_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    localparam int            CW      = ctr_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          dout_q, dout_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        if (sync_q != dout_q) begin
            if (cnt_q == CNT_MAX) begin
                dout_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = dout_q;
endmodule

// File: rtl/sos_alarm_ctrl.sv
// Emergency-request controller feeding the SOS blinker stage.
// Debounces the cab ALARM and CLEAR buttons, latches an emergency on a
// sustained ALARM press (or a motor stall when SOS_STALL_DETECT_EN is
// defined), and holds sos_en/motion_inhibit until an operator clear completes.
//   clk   : system clock (100 MHz)
//   rst_n : synchronous active-low reset
//   bus   : sos_alarm_ctrl_if.slave
//           in : alarm_btn, clear_btn, motor_busy
//           out: sos_en, motion_inhibit, sos_cause, alarm_pulse, dbg_state
// Optional feature macro: SOS_STALL_DETECT_EN (motor stall detector).
module sos_alarm_ctrl
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 200_000_000,
    parameter int CLEAR_CYCLES    = 300_000_000,
    parameter int STALL_CYCLES    = 1_000_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    sos_alarm_ctrl_if.slave  bus
);
    localparam int            HW       = ctr_w(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam int            CLW      = ctr_w(CLEAR_CYCLES);
    localparam logic [CLW-1:0] CLR_MAX = CLW'(CLEAR_CYCLES - 1);

    logic alarm_db;
    logic clear_db;

    sos_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_alarm (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.alarm_btn),
        .dout (alarm_db)
    );

    sos_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.clear_btn),
        .dout (clear_db)
    );

    sos_state_t     state_q, state_d;
    logic [HW-1:0]  hold_ctr_q, hold_ctr_d;
    logic [CLW-1:0] clr_ctr_q, clr_ctr_d;
    logic           sos_en_q, sos_en_d;
    logic           inhibit_q, inhibit_d;
    sos_cause_t     cause_q, cause_d;
    logic           pulse_q, pulse_d;
    logic           stall_hit;
    logic           clear_ok;

    // A clear only makes progress while CLEAR is held and ALARM is released.
    assign clear_ok = clear_db && !alarm_db;

`ifdef SOS_STALL_DETECT_EN
    localparam int            SW        = ctr_w(STALL_CYCLES);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES - 1);

    logic [SW-1:0] stall_ctr_q, stall_ctr_d;

    assign stall_hit = bus.motor_busy && (stall_ctr_q == STALL_MAX);

    // Counts only while armed-capable (IDLE/ARMING) and the motor is busy;
    // forced to 0 once an emergency is active.
    always_comb begin
        stall_ctr_d = '0;
        if (bus.motor_busy && (state_d == IDLE || state_d == ARMING)) begin
            stall_ctr_d = (stall_ctr_q == STALL_MAX) ? stall_ctr_q
                                                     : stall_ctr_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_ctr_q <= '0;
        end else begin
            stall_ctr_q <= stall_ctr_d;
        end
    end
`else
    logic unused_motor_busy;
    assign unused_motor_busy = bus.motor_busy;
    assign stall_hit         = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hold_ctr_d = hold_ctr_q;
        clr_ctr_d  = clr_ctr_q;
        cause_d    = cause_q;
        case (state_q)
            IDLE: begin
                hold_ctr_d = '0;
                clr_ctr_d  = '0;
                if (stall_hit) begin
                    state_d = ALARM;
                    cause_d = CAUSE_STALL;
                end else if (alarm_db) begin
                    state_d = ARMING;
                end
            end
            ARMING: begin
                // Button completion outranks a stall firing in the same cycle.
                if (alarm_db && hold_ctr_q == HOLD_MAX) begin
                    state_d = ALARM;
                    cause_d = CAUSE_BTN;
                end else if (stall_hit) begin
                    state_d = ALARM;
                    cause_d = CAUSE_STALL;
                end else if (!alarm_db) begin
                    state_d    = IDLE;
                    hold_ctr_d = '0;
                end else begin
                    hold_ctr_d = hold_ctr_q + HW'(1);
                end
            end
            ALARM: begin
                hold_ctr_d = '0;
                clr_ctr_d  = '0;
                if (clear_ok) begin
                    state_d = CLEARING;
                end
            end
            CLEARING: begin
                if (!clear_ok) begin
                    state_d   = ALARM;
                    clr_ctr_d = '0;
                end else if (clr_ctr_q == CLR_MAX) begin
                    state_d   = IDLE;
                    clr_ctr_d = '0;
                    cause_d   = CAUSE_NONE;
                end else begin
                    clr_ctr_d = clr_ctr_q + CLW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        sos_en_d  = (state_d == ALARM) || (state_d == CLEARING);
        inhibit_d = sos_en_d;
        // Strobe only on a fresh emergency, never on CLEARING -> ALARM.
        pulse_d   = (state_d == ALARM) && (state_q == IDLE || state_q == ARMING);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_ctr_q <= '0;
            clr_ctr_q  <= '0;
            sos_en_q   <= 1'b0;
            inhibit_q  <= 1'b0;
            cause_q    <= CAUSE_NONE;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_ctr_q <= hold_ctr_d;
            clr_ctr_q  <= clr_ctr_d;
            sos_en_q   <= sos_en_d;
            inhibit_q  <= inhibit_d;
            cause_q    <= cause_d;
            pulse_q    <= pulse_d;
        end
    end

    assign bus.sos_en         = sos_en_q;
    assign bus.motion_inhibit = inhibit_q;
    assign bus.sos_cause      = cause_q;
    assign bus.alarm_pulse    = pulse_q;
    assign bus.dbg_state      = state_q;
endmodule
